// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage and IF/ID pipeline register for the
//               16-bit processor. Owns the PC, runs a request/ready
//               instruction-memory port and hands one instruction per cycle
//               to decode, handling stalls, redirects, wait states and halt.
// Ports       : clk, rst            - clock, async active-high reset
//               stall               - hold PC and IF/ID this cycle
//               redirect_valid/_pc  - taken branch/jump target from execute
//               halt_d              - decode holds a valid HALT
//               imem_req/addr       - memory request and fetch address (= pc)
//               imem_rdata/ready    - memory data and access completion
//               if_id_instr/pc_plus2/valid - IF/ID register to decode
//               halted              - fetch permanently stopped
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_d,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,   // issue request at pc (unless stalled)
        S_WAIT    = 3'd1,   // access outstanding, address held
        S_HOLD    = 3'd2,   // data arrived under stall, parked in hold_instr
        S_DRAIN   = 3'd3,   // finish a stale access, then jump to pend_pc
        S_HALTING = 3'd4,   // finish a stale access, then stop
        S_HALTED  = 3'd5    // stopped until reset
    } state_t;

    state_t      r_state_q,      w_state_d;
    logic [15:0] r_pc_q,         w_pc_d;
    logic [15:0] r_instr_q,      w_instr_d;
    logic [15:0] r_pc_plus2_q,   w_pc_plus2_d;
    logic        r_valid_q,      w_valid_d;
    logic [15:0] r_pend_pc_q,    w_pend_pc_d;
    logic [15:0] r_hold_instr_q, w_hold_instr_d;

    logic [15:0] w_pc_inc;
    logic        w_deliver;
    logic        w_bubble;
    logic [15:0] w_deliver_data;
    logic        w_req;

    // Natural 16-bit overflow gives the required wrap from 16'hFFFE to 0.
    assign w_pc_inc = r_pc_q + 16'd2;

    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_pend_pc_d    = r_pend_pc_q;
        w_hold_instr_d = r_hold_instr_q;
        w_deliver      = 1'b0;
        w_bubble       = 1'b0;
        w_deliver_data = imem_rdata;

        case (r_state_q)
            S_FETCH, S_WAIT, S_HOLD, S_DRAIN: begin
                // A same-cycle redirect squashes the halt, so halt only acts alone.
                if (halt_d && !redirect_valid) begin
                    w_bubble = 1'b1;
                    if (r_state_q == S_WAIT || r_state_q == S_DRAIN) begin
                        w_state_d = S_HALTING;
                    end else begin
                        w_state_d = S_HALTED;
                    end
                end else begin
                    case (r_state_q)
                        S_FETCH: begin
                            if (redirect_valid) begin
                                w_pc_d   = redirect_pc;
                                w_bubble = 1'b1;
                            end else if (stall) begin
                                w_state_d = S_FETCH;
                            end else if (imem_ready) begin
                                w_deliver = 1'b1;
                            end else begin
                                w_bubble  = 1'b1;
                                w_state_d = S_WAIT;
                            end
                        end
                        S_WAIT: begin
                            if (redirect_valid) begin
                                w_bubble = 1'b1;
                                if (imem_ready) begin
                                    w_pc_d    = redirect_pc;
                                    w_state_d = S_FETCH;
                                end else begin
                                    // The access at the old pc must still complete.
                                    w_pend_pc_d = redirect_pc;
                                    w_state_d   = S_DRAIN;
                                end
                            end else if (imem_ready) begin
                                if (stall) begin
                                    w_hold_instr_d = imem_rdata;
                                    w_state_d      = S_HOLD;
                                end else begin
                                    w_deliver = 1'b1;
                                    w_state_d = S_FETCH;
                                end
                            end else if (!stall) begin
                                w_bubble = 1'b1;
                            end
                        end
                        S_HOLD: begin
                            if (redirect_valid) begin
                                w_pc_d    = redirect_pc;
                                w_bubble  = 1'b1;
                                w_state_d = S_FETCH;
                            end else if (!stall) begin
                                w_deliver      = 1'b1;
                                w_deliver_data = r_hold_instr_q;
                                w_state_d      = S_FETCH;
                            end
                        end
                        S_DRAIN: begin
                            w_bubble = 1'b1;
                            if (redirect_valid) begin
                                w_pend_pc_d = redirect_pc;
                            end
                            if (imem_ready) begin
                                // The newest redirect target is the one to follow.
                                w_pc_d    = redirect_valid ? redirect_pc : r_pend_pc_q;
                                w_state_d = S_FETCH;
                            end
                        end
                        default: begin
                            w_state_d = r_state_q;
                        end
                    endcase
                end
            end
            S_HALTING: begin
                if (imem_ready) begin
                    w_state_d = S_HALTED;
                end
            end
            default: begin
                w_state_d = r_state_q;
            end
        endcase

        w_instr_d    = r_instr_q;
        w_pc_plus2_d = r_pc_plus2_q;
        w_valid_d    = r_valid_q;
        if (w_deliver) begin
            w_instr_d    = w_deliver_data;
            w_pc_plus2_d = w_pc_inc;
            w_valid_d    = 1'b1;
            w_pc_d       = w_pc_inc;
        end else if (w_bubble) begin
            w_instr_d = NOP_INSTR;
            w_valid_d = 1'b0;
        end
    end

    always_comb begin
        case (r_state_q)
            S_FETCH:                   w_req = !stall;
            S_WAIT, S_DRAIN, S_HALTING: w_req = 1'b1;
            default:                   w_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= S_FETCH;
            r_pc_q         <= RESET_PC;
            r_instr_q      <= NOP_INSTR;
            r_pc_plus2_q   <= 16'h0000;
            r_valid_q      <= 1'b0;
            r_pend_pc_q    <= 16'h0000;
            r_hold_instr_q <= 16'h0000;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_instr_q      <= w_instr_d;
            r_pc_plus2_q   <= w_pc_plus2_d;
            r_valid_q      <= w_valid_d;
            r_pend_pc_q    <= w_pend_pc_d;
            r_hold_instr_q <= w_hold_instr_d;
        end
    end

    // Gating with rst lets reset abandon an in-flight access immediately.
    assign imem_req       = w_req && !rst;
    assign imem_addr      = r_pc_q;
    assign if_id_instr    = r_instr_q;
    assign if_id_pc_plus2 = r_pc_plus2_q;
    assign if_id_valid    = r_valid_q;
    assign halted         = (r_state_q == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A driver applies
//               directed and random stimulus, advances a transaction-level
//               reference model and queues the expected per-cycle outputs;
//               a monitor pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [15:0] C_NOP      = 16'h0800;
    localparam logic [15:0] C_RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_d;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    // Memory returns C000 + address for every location.
    assign imem_rdata = 16'hC000 + imem_addr;

    fetch_stage #(
        .RESET_PC (C_RESET_PC),
        .NOP_INSTR(C_NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_d        (halt_d),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    typedef struct packed {
        logic        req;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pcp2;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // ---------------- reference model ----------------
    logic [15:0] m_pc, m_instr, m_pcp2;
    logic        m_valid, m_halted;
    logic        m_waiting;   // an access at m_pc is outstanding
    logic        m_halting;   // outstanding access is to be dropped, then stop
    logic [15:0] m_held[$];   // instruction parked while stalled
    logic [15:0] m_drain[$];  // redirect target waiting for a stale access

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hC000 + a;
    endfunction

    task automatic model_reset();
        m_pc = C_RESET_PC; m_instr = C_NOP; m_pcp2 = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0; m_waiting = 1'b0; m_halting = 1'b0;
        m_held.delete(); m_drain.delete();
    endtask

    task automatic m_deliver(input logic [15:0] x);
        m_instr = x; m_pcp2 = m_pc + 16'd2; m_valid = 1'b1; m_pc = m_pc + 16'd2;
    endtask

    task automatic m_bubble();
        m_instr = C_NOP; m_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus: drive, queue expectation, advance the model.
    task automatic step(input logic st, input logic rv, input logic [15:0] rpc,
                        input logic hd, input logic rdy);
        exp_t e;
        logic [15:0] tgt;
        stall = st; redirect_valid = rv; redirect_pc = rpc; halt_d = hd; imem_ready = rdy;

        if (m_halted)                                          e.req = 1'b0;
        else if (m_held.size() != 0)                           e.req = 1'b0;
        else if (m_waiting || m_halting || m_drain.size() != 0) e.req = 1'b1;
        else                                                   e.req = !st;
        e.addr = m_pc; e.instr = m_instr; e.pcp2 = m_pcp2;
        e.valid = m_valid; e.halted = m_halted;
        sb_q.push_back(e);

        if (m_halted) begin
            // frozen
        end else if (m_halting) begin
            if (rdy) begin m_halting = 1'b0; m_halted = 1'b1; end
        end else if (hd && !rv) begin
            m_bubble();
            if (m_waiting || m_drain.size() != 0) m_halting = 1'b1;
            else                                  m_halted  = 1'b1;
            m_waiting = 1'b0; m_held.delete(); m_drain.delete();
        end else if (m_drain.size() != 0) begin
            m_bubble();
            tgt = rv ? rpc : m_drain[0];
            m_drain.delete();
            if (rdy) m_pc = tgt;
            else     m_drain.push_back(tgt);
        end else if (m_held.size() != 0) begin
            if (rv) begin
                m_held.delete(); m_pc = rpc; m_bubble();
            end else if (!st) begin
                m_deliver(m_held[0]); m_held.delete();
            end
        end else if (m_waiting) begin
            if (rv) begin
                m_bubble(); m_waiting = 1'b0;
                if (rdy) m_pc = rpc;
                else     m_drain.push_back(rpc);
            end else if (rdy) begin
                m_waiting = 1'b0;
                if (st) m_held.push_back(mem_word(m_pc));
                else    m_deliver(mem_word(m_pc));
            end else if (!st) begin
                m_bubble();
            end
        end else begin
            if (rv) begin
                m_pc = rpc; m_bubble();
            end else if (st) begin
                // hold
            end else if (rdy) begin
                m_deliver(mem_word(m_pc));
            end else begin
                m_bubble(); m_waiting = 1'b1;
            end
        end

        @(posedge clk); #1;
    endtask

    // Asynchronous reset taken between edges; request must drop at once.
    task automatic do_reset();
        mon_en = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; halt_d = 1'b0; imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_imem_req", {15'd0, imem_req}, 16'd0);
        chk("rst_imem_addr", imem_addr, C_RESET_PC);
        chk("rst_if_id_instr", if_id_instr, C_NOP);
        chk("rst_if_id_pc_plus2", if_id_pc_plus2, 16'h0000);
        chk("rst_if_id_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty cycle=%0d actual=0 expected=1 entries", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("imem_req", {15'd0, imem_req}, {15'd0, mon_e.req});
                chk("imem_addr", imem_addr, mon_e.addr);
                chk("if_id_instr", if_id_instr, mon_e.instr);
                chk("if_id_pc_plus2", if_id_pc_plus2, mon_e.pcp2);
                chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, mon_e.valid});
                chk("halted", {15'd0, halted}, {15'd0, mon_e.halted});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        halt_d = 1'b0; imem_ready = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        do_reset();

        // Back-to-back ready from address 0.
        for (int i = 0; i < 2; i++) step(0, 0, 16'h0, 0, 1);
        // Wait states at address 4: three bubbles, then 4 and 6 delivered.
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 0, 1);
        // Ready under stall at address 8: park, then release.
        step(0, 0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 0, 1);
        step(1, 0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 1);
        // Redirect to 0x0100 while waiting at 12.
        step(0, 0, 16'h0, 0, 0);
        step(0, 1, 16'h0100, 0, 0);
        step(0, 0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 0, 1);
        // PC wrap at 16'hFFFE.
        step(0, 1, 16'hFFFE, 0, 1);
        step(0, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 0, 1);
        // Halt squashed by a simultaneous redirect, then a real halt.
        step(0, 1, 16'h0200, 1, 1);
        step(0, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 1, 1);
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom) & 16'hFFFE,
                 $urandom_range(0, 1), $urandom_range(0, 1));
        // Halt while waiting goes through the halting drain.
        do_reset();
        step(0, 0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 1, 0);
        step(0, 1, 16'h0300, 0, 0);
        step(0, 0, 16'h0, 0, 1);
        step(0, 1, 16'h0300, 0, 1);
        // Reset during an outstanding access.
        step(0, 0, 16'h0, 0, 0);
        do_reset();

        // Randomised traffic; a halted core is revived by reset.
        for (int i = 0; i < 3000; i++) begin
            if (m_halted && ($urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) == 0,
                     16'($urandom) & 16'hFFFE,
                     $urandom_range(0, 99) == 0,
                     $urandom_range(0, 2) != 0);
            end
        end

        mon_en = 1'b0;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0 entries", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
